// File: rtl/network_pkg.sv
// Shared definitions for the Network control path: sequencer state encoding,
// default batch/gap/watchdog constants and a width helper.
package network_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    localparam int unsigned RUNS_DEFAULT           = 3;
    localparam int unsigned GAP_CYCLES_DEFAULT     = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

    // Index/counter width that never collapses to zero bits.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/network_run_sequencer_rise_detect.sv
// Rising-edge detector for the Network done level; holds the done_q history register.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= d;
        end
    end

    assign rise = d & ~done_q;

endmodule

// File: rtl/network_run_sequencer.sv
// Runs Network RUNS times per go request with idle gaps, capturing each out bit.
// Optional per-run watchdog enabled by defining SEQ_TIMEOUT_EN.
module network_run_sequencer
    import network_pkg::*;
#(
    parameter int unsigned RUNS           = RUNS_DEFAULT,
    parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        go,
    input  logic                        net_done,
    input  logic                        net_out,
    output logic                        net_start,
    output logic                        busy,
    output logic                        batch_done,
    output logic [RUNS-1:0]             results,
    output logic [$clog2(RUNS+1)-1:0]   run_count,
    output logic                        timeout
);

    localparam int unsigned CW = $clog2(RUNS + 1);
    localparam int unsigned IW = width_of(RUNS);
    localparam int unsigned GW = width_of(GAP_CYCLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(RUNS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    seq_state_t     state, state_n;
    logic [IW-1:0]  idx, idx_n;
    logic [GW-1:0]  gap_cnt, gap_n;
    logic [RUNS-1:0] results_n;
    logic [CW-1:0]  count_n;
    logic           net_rise;
    logic           done_rise;

    rise_detect u_rise (
        .clk   (clk),
        .reset (reset),
        .d     (net_done),
        .rise  (net_rise)
    );

    assign done_rise = net_rise & (state == RUN);

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TW = width_of(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt, tcnt_n;
    logic          timeout_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            tcnt    <= tcnt_n;
            timeout <= timeout_n;
        end
    end
`else
    assign timeout = 1'b0;

    // Keeps the watchdog limit parameter referenced when the watchdog is absent.
    if (TIMEOUT_CYCLES == 0) begin : g_unused_timeout_limit
    end
`endif

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        gap_n     = gap_cnt;
        results_n = results;
        count_n   = run_count;
`ifdef SEQ_TIMEOUT_EN
        tcnt_n    = tcnt;
        timeout_n = timeout;
`endif
        unique case (state)
            IDLE: begin
                if (go) begin
                    results_n = '0;
                    count_n   = '0;
                    idx_n     = '0;
`ifdef SEQ_TIMEOUT_EN
                    tcnt_n    = '0;
                    timeout_n = 1'b0;
`endif
                    state_n   = RUN;
                end
            end
            RUN: begin
                // The index parks on the last run so it never exceeds RUNS-1.
                if (done_rise) begin
                    results_n[idx] = net_out;
                    count_n        = run_count + 1'b1;
                    if (idx == LAST_IDX) begin
                        state_n = FINISH;
                    end else begin
                        idx_n   = idx + 1'b1;
                        gap_n   = '0;
                        state_n = GAP;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tcnt == TOUT_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = FINISH;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
`endif
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = RUN;
`ifdef SEQ_TIMEOUT_EN
                    tcnt_n  = '0;
`endif
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every output leaves a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            gap_cnt    <= '0;
            results    <= '0;
            run_count  <= '0;
            net_start  <= 1'b0;
            busy       <= 1'b0;
            batch_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            gap_cnt    <= gap_n;
            results    <= results_n;
            run_count  <= count_n;
            net_start  <= (state_n == RUN);
            busy       <= (state_n != IDLE);
            batch_done <= (state_n == FINISH);
        end
    end

endmodule

// File: tb/tb_network_run_sequencer.sv
// Self-checking bench for network_run_sequencer with a behavioural Network model.
// Timeout scenario runs only when SEQ_TIMEOUT_EN is defined.
module tb_network_run_sequencer;

    localparam int RUNS = 3;
    localparam int GAP  = 4;
    localparam int TOUT = 16;
    localparam int CW   = $clog2(RUNS + 1);

    logic clk = 1'b0;
    logic reset, go, net_done, net_out;
    logic net_start, busy, batch_done, timeout;
    logic [RUNS-1:0] results;
    logic [CW-1:0]   run_count;

    network_run_sequencer #(
        .RUNS           (RUNS),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .net_done   (net_done),
        .net_out    (net_out),
        .net_start  (net_start),
        .busy       (busy),
        .batch_done (batch_done),
        .results    (results),
        .run_count  (run_count),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Network model and batch observation state
    logic [RUNS-1:0] outs = '0;
    int  lat = 0, stall = -1, force_done = -1;
    int  run_i = 0, start_cnt = 0, low_len = 0, gaps_seen = 0, bd_count = 0;
    bit  prev_start = 0, in_batch = 0, gaps_bad = 0, busy_bad = 0;

    typedef struct {
        logic [RUNS-1:0] outs;
        int              lat;
        bit              spam;
        int              hold;
        logic [RUNS-1:0] exp_results;
        int              exp_count;
        int              exp_len;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: observe outputs after the edge, then drive this cycle's Network response.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (batch_done) bd_count++;
        if (in_batch && !busy) busy_bad = 1;
        if (net_start) begin
            if (!prev_start && low_len > 0) begin
                gaps_seen++;
                if (low_len != GAP) gaps_bad = 1;
            end
            low_len = 0;
            start_cnt++;
        end else begin
            if (prev_start) run_i++;
            if (in_batch) low_len++;
            start_cnt = 0;
        end
        prev_start = net_start;
        net_out = (run_i < RUNS) ? outs[run_i] : 1'b0;
        if (force_done >= 0) net_done = force_done[0];
        else net_done = net_start && (start_cnt > lat) && (run_i != stall);
    endtask

    task automatic model_init(input logic [RUNS-1:0] o, input int l, input int stl);
        outs = o; lat = l; stall = stl;
        run_i = 0; start_cnt = 0; low_len = 0; gaps_seen = 0;
        bd_count = 0; gaps_bad = 0; busy_bad = 0;
    endtask

    task automatic run_batch(input logic [RUNS-1:0] o, input int l, input bit spam,
                             input int hold, input int stl,
                             output logic [RUNS-1:0] r, output int cnt, output int bdc,
                             output int len, output bit to, output bit gaps_ok,
                             output bit busy_ok);
        int t0;
        int budget;
        model_init(o, l, stl);
        if (hold > 0) begin
            force_done = 1;
            net_done = 1'b1;
            repeat (3) cycle();
        end
        go = 1'b1;
        t0 = cyc;
        cycle();
        in_batch = 1;
        if (!spam) go = 1'b0;
        if (hold > 0) begin
            repeat (hold - 1) cycle();
            check("hold_no_capture", run_count, 0);
            force_done = 0;
            cycle();
            force_done = -1;
        end
        budget = 0;
        while (!batch_done && budget < 2000) begin
            cycle();
            budget++;
        end
        check("batch_done_seen", batch_done, 1);
        len = cyc - t0;
        r   = results;
        cnt = run_count;
        to  = timeout;
        in_batch = 0;
        cycle();
        go = 1'b0;
        repeat (4) cycle();
        bdc     = bd_count;
        gaps_ok = !gaps_bad && (gaps_seen == RUNS - 1);
        busy_ok = !busy_bad && !busy;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic [RUNS-1:0] r, exp_r, keep_r;
        int cnt, bdc, len, exp_len, keep_c;
        bit to, gaps_ok, busy_ok;
        bit run_q[$];

        vecs[0] = '{3'b101, 2, 1'b0, 0, 3'b101, 3, 18};
        vecs[1] = '{3'b000, 0, 1'b0, 0, 3'b000, 3, 12};
        vecs[2] = '{3'b111, 5, 1'b1, 0, 3'b111, 3, 27};
        vecs[3] = '{3'b010, 1, 1'b0, 0, 3'b010, 3, 15};
        vecs[4] = '{3'b110, 0, 1'b0, 4, 3'b110, 3, 17};
        vecs[5] = '{3'b011, 3, 1'b1, 0, 3'b011, 3, 21};

        reset = 1'b0; go = 1'b0; net_done = 1'b0; net_out = 1'b0;

        // Reset held 30 cycles with net_done activity
        for (int i = 0; i < 30; i++) begin
            force_done = (i % 3 == 0) ? 1 : 0;
            cycle();
            if (i == 10 || i == 29)
                check("reset_outputs", {net_start, busy, batch_done, timeout, results, run_count}, 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            force_done = (i % 4 < 2) ? 1 : 0;
            cycle();
            check("idle_outputs", {net_start, busy, batch_done, timeout, results, run_count}, 0);
        end
        force_done = -1;
        net_done = 1'b0;
        cycle();

        // Table-driven batches
        for (int v = 0; v < 6; v++) begin
            run_batch(vecs[v].outs, vecs[v].lat, vecs[v].spam, vecs[v].hold, -1,
                      r, cnt, bdc, len, to, gaps_ok, busy_ok);
            check($sformatf("vec%0d_results", v), r, vecs[v].exp_results);
            check($sformatf("vec%0d_run_count", v), cnt, vecs[v].exp_count);
            check($sformatf("vec%0d_batch_done_pulses", v), bdc, 1);
            check($sformatf("vec%0d_batch_len", v), len, vecs[v].exp_len);
            check($sformatf("vec%0d_gaps_ok", v), gaps_ok, 1);
            check($sformatf("vec%0d_busy_ok", v), busy_ok, 1);
            check($sformatf("vec%0d_timeout", v), to, 0);
        end

        // Randomized batches against the reference model, with idle-time done noise
        for (int n = 0; n < 10; n++) begin
            logic [RUNS-1:0] o;
            int l;
            bit spam;
            o = RUNS'($urandom);
            l = int'($urandom_range(0, 6));
            spam = bit'($urandom_range(0, 1));
            run_q.delete();
            for (int i = 0; i < RUNS; i++) run_q.push_back(o[i]);
            exp_r = '0;
            for (int i = 0; i < RUNS; i++) exp_r[i] = run_q[i];
            exp_len = RUNS * (l + 1) + (RUNS - 1) * GAP + 1;
            run_batch(o, l, spam, 0, -1, r, cnt, bdc, len, to, gaps_ok, busy_ok);
            check($sformatf("rnd%0d_results", n), r, exp_r);
            check($sformatf("rnd%0d_run_count", n), cnt, RUNS);
            check($sformatf("rnd%0d_batch_done_pulses", n), bdc, 1);
            check($sformatf("rnd%0d_batch_len", n), len, exp_len);
            check($sformatf("rnd%0d_gaps_ok", n), gaps_ok, 1);
            check($sformatf("rnd%0d_busy_ok", n), busy_ok, 1);
            keep_r = exp_r;
            keep_c = RUNS;
            bd_count = 0;
            for (int i = 0; i < 10; i++) begin
                force_done = int'($urandom_range(0, 1));
                cycle();
            end
            force_done = -1;
            net_done = 1'b0;
            cycle();
            check($sformatf("rnd%0d_idle_hold", n), {busy, results, run_count}, {1'b0, keep_r, CW'(keep_c)});
            check($sformatf("rnd%0d_idle_no_pulse", n), bd_count, 0);
        end

        // Reset asserted during the gap after run 2
        model_init(3'b111, 1, -1);
        go = 1'b1;
        cycle();
        go = 1'b0;
        for (int b = 0; b < 200 && !(run_count == 2 && !net_start); b++) cycle();
        check("abort_reached_gap", {run_count, net_start, busy}, {CW'(2), 1'b0, 1'b1});
        #2;
        reset = 1'b0;
        #1;
        check("abort_async_clear", {net_start, busy, results, run_count}, 0);
        force_done = 0;
        repeat (2) cycle();
        check("abort_held_clear", {net_start, busy, batch_done, results, run_count}, 0);
        reset = 1'b1;
        cycle();
        force_done = -1;
        run_batch(3'b001, 2, 1'b0, 0, -1, r, cnt, bdc, len, to, gaps_ok, busy_ok);
        check("post_abort_results", r, 3'b001);
        check("post_abort_run_count", cnt, 3);
        check("post_abort_pulses", bdc, 1);
        check("post_abort_len", len, 18);

`ifdef SEQ_TIMEOUT_EN
        // Run 2 never completes: watchdog ends the batch after TOUT RUN cycles
        run_batch(3'b101, 2, 1'b0, 0, 1, r, cnt, bdc, len, to, gaps_ok, busy_ok);
        check("tout_flag", to, 1);
        check("tout_run_count", cnt, 1);
        check("tout_pulses", bdc, 1);
        check("tout_results", r, 3'b001);
        check("tout_len", len, (2 + 1) + GAP + TOUT + 1);
        check("tout_sticky", timeout, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
